// File: rtl/sync_chain.sv
// sync_chain: per-bit NUM_FFS-stage level synchronizer into the clk domain, with optional rise/fall pulses.
// Build option: define SYNC_CHAIN_EDGE_EN to build sync_rise/sync_fall; when undefined both are tied low.
module sync_chain #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      NUM_FFS = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_sig,
    output logic [WIDTH-1:0] sync_sig,
    output logic [WIDTH-1:0] sync_rise,
    output logic [WIDTH-1:0] sync_fall
);

    generate
        if (NUM_FFS < 2 || NUM_FFS > 8) begin : g_bad_depth
            $error("sync_chain: NUM_FFS must be in 2..8");
        end
    endgenerate

    // Index 0 samples the asynchronous pin; index NUM_FFS-1 is the settled output.
    // The attributes keep the chain unmerged, adjacent and out of retiming.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [NUM_FFS-1:0][WIDTH-1:0] stages;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value; blocking here would collapse
    // the chain into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= {NUM_FFS{RST_VAL}};
        end else begin
            stages <= {stages[NUM_FFS-2:0], async_sig};
        end
    end

    assign sync_sig = stages[NUM_FFS-1];

`ifdef SYNC_CHAIN_EDGE_EN
    // History resets to the same value as the chain, so leaving reset cannot pulse.
    logic [WIDTH-1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= RST_VAL;
        end else begin
            hist <= sync_sig;
        end
    end

    assign sync_rise = sync_sig & ~hist;
    assign sync_fall = ~sync_sig & hist;
`else
    assign sync_rise = '0;
    assign sync_fall = '0;
`endif

endmodule

// File: tb/tb_sync_chain.sv
// tb_sync_chain: directed self-checking bench for sync_chain at depths 2, 3, 4 and a 4-bit instance.
// Expected pulse values follow SYNC_CHAIN_EDGE_EN: zero when the option is not built.
module tb_sync_chain;

`ifdef SYNC_CHAIN_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       a2, a3, a4;
    logic [3:0] aw;
    logic       s2, r2, f2;
    logic       s3, r3, f3;
    logic       s4, r4, f4;
    logic [3:0] sw, rw, fw;

    int vectors;
    int miscompares;

    sync_chain #(.WIDTH(1), .NUM_FFS(2), .RST_VAL(1'b0)) dut2 (
        .clk(clk), .rst(rst), .async_sig(a2),
        .sync_sig(s2), .sync_rise(r2), .sync_fall(f2)
    );
    sync_chain #(.WIDTH(1), .NUM_FFS(3), .RST_VAL(1'b0)) dut3 (
        .clk(clk), .rst(rst), .async_sig(a3),
        .sync_sig(s3), .sync_rise(r3), .sync_fall(f3)
    );
    sync_chain #(.WIDTH(1), .NUM_FFS(4), .RST_VAL(1'b0)) dut4 (
        .clk(clk), .rst(rst), .async_sig(a4),
        .sync_sig(s4), .sync_rise(r4), .sync_fall(f4)
    );
    sync_chain #(.WIDTH(4), .NUM_FFS(2), .RST_VAL(4'b1010)) dutw (
        .clk(clk), .rst(rst), .async_sig(aw),
        .sync_sig(sw), .sync_rise(rw), .sync_fall(fw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // One rising edge, then back to the falling edge where inputs change and outputs are sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [2:0] exp;
        rst = 1'b1;
        a2  = 1'b1;
        a3  = 1'b0;
        a4  = 1'b0;
        aw  = 4'b1010;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({s2, r2, f2} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: {sync,rise,fall} got %b want 000", i, {s2, r2, f2});
            end
            if (i == 0) tick();
        end
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            exp = {n >= 2, EDGE && n == 2, 1'b0};
            vectors++;
            if ({s2, r2, f2} !== exp) begin
                miscompares++;
                $display("FAIL reset_release edge%0d: {sync,rise,fall} got %b want %b", n, {s2, r2, f2}, exp);
            end
        end
    endtask

    task automatic test_latency_rise();
        logic [2:0] exp;
        a2 = 1'b0;
        repeat (4) tick();
        a2 = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            exp = {n >= 2, EDGE && n == 2, 1'b0};
            vectors++;
            if ({s2, r2, f2} !== exp) begin
                miscompares++;
                $display("FAIL latency_rise edge%0d: {sync,rise,fall} got %b want %b", n, {s2, r2, f2}, exp);
            end
        end
    endtask

    task automatic test_latency_fall();
        logic [2:0] exp;
        a2 = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            exp = {n < 2, 1'b0, EDGE && n == 2};
            vectors++;
            if ({s2, r2, f2} !== exp) begin
                miscompares++;
                $display("FAIL latency_fall edge%0d: {sync,rise,fall} got %b want %b", n, {s2, r2, f2}, exp);
            end
        end
    endtask

    task automatic test_depth();
        logic [2:0] e3, e4;
        for (int pass = 0; pass < 2; pass++) begin
            a3 = (pass == 0);
            a4 = (pass == 0);
            for (int n = 1; n <= 5; n++) begin
                tick();
                if (pass == 0) begin
                    e3 = {n >= 3, EDGE && n == 3, 1'b0};
                    e4 = {n >= 4, EDGE && n == 4, 1'b0};
                end else begin
                    e3 = {n < 3, 1'b0, EDGE && n == 3};
                    e4 = {n < 4, 1'b0, EDGE && n == 4};
                end
                vectors++;
                if ({s3, r3, f3} !== e3) begin
                    miscompares++;
                    $display("FAIL depth3 pass%0d edge%0d: {sync,rise,fall} got %b want %b", pass, n, {s3, r3, f3}, e3);
                end
                vectors++;
                if ({s4, r4, f4} !== e4) begin
                    miscompares++;
                    $display("FAIL depth4 pass%0d edge%0d: {sync,rise,fall} got %b want %b", pass, n, {s4, r4, f4}, e4);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic d1, d2, exp_s;
        logic [2:0] exp;
        d1 = 1'b0;
        d2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a2 = ~i[0];
            tick();
            // After edge i, sync shows the value driven before edge i-1.
            exp_s = d1;
            exp = {exp_s, EDGE & exp_s & ~d2, EDGE & ~exp_s & d2};
            vectors++;
            if ({s2, r2, f2} !== exp) begin
                miscompares++;
                $display("FAIL toggle step%0d: {sync,rise,fall} got %b want %b", i, {s2, r2, f2}, exp);
            end
            d2 = d1;
            d1 = a2;
        end
        a2 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_multibit();
        logic [11:0] exp;
        for (int n = 0; n < 2; n++) begin
            vectors++;
            if ({sw, rw, fw} !== {4'b1010, 4'b0000, 4'b0000}) begin
                miscompares++;
                $display("FAIL multibit_idle%0d: {sync,rise,fall} got %b want 101000000000", n, {sw, rw, fw});
            end
            tick();
        end
        aw = 4'b0101;
        for (int n = 1; n <= 3; n++) begin
            tick();
            if (n < 2)       exp = {4'b1010, 4'b0000, 4'b0000};
            else if (n == 2) exp = {4'b0101, EDGE ? 4'b0101 : 4'b0000, EDGE ? 4'b1010 : 4'b0000};
            else             exp = {4'b0101, 4'b0000, 4'b0000};
            vectors++;
            if ({sw, rw, fw} !== exp) begin
                miscompares++;
                $display("FAIL multibit edge%0d: {sync,rise,fall} got %b want %b", n, {sw, rw, fw}, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] exp;
        a2 = 1'b1;
        repeat (3) tick();
        vectors++;
        if (s2 !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_pre: sync got %b want 1", s2);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({s2, r2, f2} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_reset_in: {sync,rise,fall} got %b want 000", {s2, r2, f2});
        end
        vectors++;
        if ({sw, rw, fw} !== {4'b1010, 4'b0000, 4'b0000}) begin
            miscompares++;
            $display("FAIL mid_reset_wide: {sync,rise,fall} got %b want 101000000000", {sw, rw, fw});
        end
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            exp = {n >= 2, EDGE && n == 2, 1'b0};
            vectors++;
            if ({s2, r2, f2} !== exp) begin
                miscompares++;
                $display("FAIL mid_reset_release edge%0d: {sync,rise,fall} got %b want %b", n, {s2, r2, f2}, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_latency_rise();
        test_latency_fall();
        test_depth();
        test_back_to_back();
        test_multibit();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
